// File: rtl/img_pkg.sv
// Shared pixel widths, sepia offsets and state encodings for the gray-to-RGB path.
package img_pkg;

   localparam int GRAY_W      = 8;
   localparam int RGB_W       = 24;
   localparam int SEPIA_R_OFS = 40;
   localparam int SEPIA_G_OFS = 20;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_EOF    = 2'd2
   } state_e;

endpackage

// File: rtl/gray_to_rgb.sv
// Gray byte to RGB pixel expander between two FIFOs, one hold register deep, with frame tracking.
// Defining GRAY_TO_RGB_SEPIA_EN selects a saturating sepia tint instead of plain R=G=B replication.
module gray_to_rgb
   import img_pkg::*;
#(
   parameter int FIFO_DWIDTH_IN  = GRAY_W,
   parameter int FIFO_DWIDTH_OUT = RGB_W,
   parameter int FRAME_PIXELS    = 518400
) (
   input  logic                       clock,
   input  logic                       reset,
   output logic                       fifo_in_rd_en,
   input  logic [FIFO_DWIDTH_IN-1:0]  fifo_in_dout,
   input  logic                       fifo_in_empty,
   output logic                       fifo_out_wr_en,
   output logic [FIFO_DWIDTH_OUT-1:0] fifo_out_din,
   input  logic                       fifo_out_full,
   output logic                       frame_done
);

   localparam int               CNT_W      = $clog2(FRAME_PIXELS + 1);
   localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_PIXELS);

   function automatic logic [FIFO_DWIDTH_OUT-1:0] expand(input logic [FIFO_DWIDTH_IN-1:0] g);
`ifdef GRAY_TO_RGB_SEPIA_EN
      logic [FIFO_DWIDTH_IN:0]   r_sum;
      logic [FIFO_DWIDTH_IN:0]   g_sum;
      logic [FIFO_DWIDTH_IN-1:0] r_sat;
      logic [FIFO_DWIDTH_IN-1:0] g_sat;
      // One extra bit catches the carry, which then forces full scale.
      r_sum = {1'b0, g} + (FIFO_DWIDTH_IN + 1)'(SEPIA_R_OFS);
      g_sum = {1'b0, g} + (FIFO_DWIDTH_IN + 1)'(SEPIA_G_OFS);
      r_sat = r_sum[FIFO_DWIDTH_IN] ? '1 : r_sum[FIFO_DWIDTH_IN-1:0];
      g_sat = g_sum[FIFO_DWIDTH_IN] ? '1 : g_sum[FIFO_DWIDTH_IN-1:0];
      return FIFO_DWIDTH_OUT'({r_sat, g_sat, g});
`else
      return FIFO_DWIDTH_OUT'({g, g, g});
`endif
   endfunction

   state_e                     state_q, state_d;
   logic [FIFO_DWIDTH_OUT-1:0] hold_data_q, hold_data_d;
   logic                       hold_valid_q, hold_valid_d;
   logic [CNT_W-1:0]           pixel_count_q, pixel_count_d;
   logic [CNT_W-1:0]           cnt_inc;
   logic                       wr_en;
   logic                       rd_en;
   logic                       last_wr;

   always_comb begin
      // Handshakes are held off while reset is asserted so nothing moves in that cycle.
      wr_en   = ~reset & hold_valid_q & ~fifo_out_full;
      rd_en   = ~reset & ~fifo_in_empty & (~hold_valid_q | wr_en) & (state_q != S_EOF);
      cnt_inc = pixel_count_q + CNT_W'(1);
      last_wr = wr_en & (cnt_inc == FRAME_LAST);

      hold_data_d   = hold_data_q;
      hold_valid_d  = hold_valid_q;
      pixel_count_d = pixel_count_q;
      state_d       = state_q;

      if (rd_en) begin
         hold_data_d  = expand(fifo_in_dout);
         hold_valid_d = 1'b1;
      end else if (wr_en) begin
         hold_valid_d = 1'b0;
      end

      if (wr_en) pixel_count_d = last_wr ? '0 : cnt_inc;

      case (state_q)
         S_EOF: state_d = S_IDLE;
         default: begin
            if (last_wr)    state_d = S_EOF;
            else if (wr_en) state_d = S_STREAM;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= S_IDLE;
         hold_data_q   <= '0;
         hold_valid_q  <= 1'b0;
         pixel_count_q <= '0;
      end else begin
         state_q       <= state_d;
         hold_data_q   <= hold_data_d;
         hold_valid_q  <= hold_valid_d;
         pixel_count_q <= pixel_count_d;
      end
   end

   assign fifo_in_rd_en  = rd_en;
   assign fifo_out_wr_en = wr_en;
   assign fifo_out_din   = hold_data_q;
   assign frame_done     = ~reset & (state_q == S_EOF);

endmodule

// File: tb/tb_gray_to_rgb.sv
// Directed bench for gray_to_rgb with FRAME_PIXELS=4; honours GRAY_TO_RGB_SEPIA_EN for expectations.
module tb_gray_to_rgb;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        fifo_in_rd_en;
   logic [7:0]  fifo_in_dout = 8'hC3;
   logic        fifo_in_empty = 1'b1;
   logic        fifo_out_wr_en;
   logic [23:0] fifo_out_din;
   logic        fifo_out_full = 1'b0;
   logic        frame_done;

   int nchk = 0;
   int nerr = 0;

   gray_to_rgb #(.FIFO_DWIDTH_IN(8), .FIFO_DWIDTH_OUT(24), .FRAME_PIXELS(4)) dut (
      .clock(clock), .reset(reset),
      .fifo_in_rd_en(fifo_in_rd_en), .fifo_in_dout(fifo_in_dout), .fifo_in_empty(fifo_in_empty),
      .fifo_out_wr_en(fifo_out_wr_en), .fifo_out_din(fifo_out_din), .fifo_out_full(fifo_out_full),
      .frame_done(frame_done)
   );

   always #5 clock = ~clock;

   // Input FIFO model and per-cycle observation log (sampled mid low phase).
   logic [7:0]  in_q[$];
   logic        pop_pend = 1'b0;
   int          cyc = 0;
   int          wr_cyc[$];
   logic [23:0] wr_dat[$];
   int          pop_cyc[$];
   int          fd_cyc[$];
   int          fd_rd_viol = 0;

   always begin
      @(negedge clock);
      cyc++;
      if (pop_pend && in_q.size() > 0) void'(in_q.pop_front());
      #1;
      fifo_in_empty = (in_q.size() == 0);
      fifo_in_dout  = (in_q.size() == 0) ? 8'hC3 : in_q[0];
      #1;
      pop_pend = fifo_in_rd_en;
      if (fifo_in_rd_en)  pop_cyc.push_back(cyc);
      if (fifo_out_wr_en) begin wr_cyc.push_back(cyc); wr_dat.push_back(fifo_out_din); end
      if (frame_done) begin
         fd_cyc.push_back(cyc);
         if (fifo_in_rd_en) fd_rd_viol++;
      end
   end

   function automatic logic [23:0] ref_px(input logic [7:0] g);
`ifdef GRAY_TO_RGB_SEPIA_EN
      int r = int'(g) + 40;
      int gg = int'(g) + 20;
      if (r > 255) r = 255;
      if (gg > 255) gg = 255;
      return {r[7:0], gg[7:0], g};
`else
      return {g, g, g};
`endif
   endfunction

   task automatic clear_logs();
      wr_cyc.delete(); wr_dat.delete(); pop_cyc.delete(); fd_cyc.delete(); fd_rd_viol = 0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1; fifo_out_full = 1'b0; in_q.delete();
      repeat (2) @(negedge clock);
      reset = 1'b0;
      clear_logs();
   endtask

   task automatic test_reset();
      @(negedge clock);
      in_q.push_back(8'h80);
      #3;
      nchk++; if (fifo_in_rd_en !== 1'b0) begin nerr++; $display("FAIL rst_rd_en got %b want 0", fifo_in_rd_en); end
      nchk++; if (fifo_out_wr_en !== 1'b0) begin nerr++; $display("FAIL rst_wr_en got %b want 0", fifo_out_wr_en); end
      @(negedge clock); #3;
      nchk++; if (fifo_out_din !== 24'h0) begin nerr++; $display("FAIL rst_din got %h want 000000", fifo_out_din); end
      nchk++; if (frame_done !== 1'b0) begin nerr++; $display("FAIL rst_frame_done got %b want 0", frame_done); end
      @(negedge clock);
      in_q.delete(); reset = 1'b0;
      #3;
      nchk++; if (fifo_out_wr_en !== 1'b0) begin nerr++; $display("FAIL post_rst_wr_en got %b want 0", fifo_out_wr_en); end
      nchk++; if (fifo_in_rd_en !== 1'b0) begin nerr++; $display("FAIL post_rst_rd_en got %b want 0", fifo_in_rd_en); end
   endtask

   task automatic test_single();
      logic [23:0] exp80;
`ifdef GRAY_TO_RGB_SEPIA_EN
      exp80 = 24'hA89480;
`else
      exp80 = 24'h808080;
`endif
      do_reset();
      in_q.push_back(8'h80);
      repeat (5) @(negedge clock);
      #3;
      nchk++; if (wr_cyc.size() !== 1) begin nerr++; $display("FAIL single_wr_count got %0d want 1", wr_cyc.size()); end
      nchk++; if (pop_cyc.size() !== 1) begin nerr++; $display("FAIL single_pop_count got %0d want 1", pop_cyc.size()); end
      if (wr_cyc.size() == 1 && pop_cyc.size() == 1) begin
         nchk++; if (wr_dat[0] !== exp80) begin nerr++; $display("FAIL single_data got %h want %h", wr_dat[0], exp80); end
         nchk++; if (wr_cyc[0] !== pop_cyc[0] + 1) begin nerr++; $display("FAIL single_latency got %0d want %0d", wr_cyc[0] - pop_cyc[0], 1); end
      end
   endtask

   task automatic test_expand_sat();
      logic [7:0]  g[4]   = '{8'hF0, 8'h00, 8'hFF, 8'h5A};
      logic [23:0] exp[4];
`ifdef GRAY_TO_RGB_SEPIA_EN
      exp = '{24'hFFFFF0, 24'h281400, 24'hFFFFFF, 24'h826E5A};
`else
      exp = '{24'hF0F0F0, 24'h000000, 24'hFFFFFF, 24'h5A5A5A};
`endif
      do_reset();
      for (int i = 0; i < 4; i++) in_q.push_back(g[i]);
      repeat (8) @(negedge clock);
      #3;
      nchk++; if (wr_dat.size() !== 4) begin nerr++; $display("FAIL expand_count got %0d want 4", wr_dat.size()); end
      if (wr_dat.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            nchk++; if (wr_dat[i] !== exp[i]) begin nerr++; $display("FAIL expand_px%0d got %h want %h", i, wr_dat[i], exp[i]); end
            nchk++; if (wr_cyc[i] !== wr_cyc[0] + i) begin nerr++; $display("FAIL expand_rate%0d got cyc %0d want %0d", i, wr_cyc[i], wr_cyc[0] + i); end
         end
         nchk++; if (fd_cyc.size() !== 1) begin nerr++; $display("FAIL expand_fd_count got %0d want 1", fd_cyc.size()); end
         else begin
            nchk++; if (fd_cyc[0] !== wr_cyc[3] + 1) begin nerr++; $display("FAIL expand_fd_cyc got %0d want %0d", fd_cyc[0], wr_cyc[3] + 1); end
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      fifo_out_full = 1'b1;
      in_q.push_back(8'h11); in_q.push_back(8'h22); in_q.push_back(8'h33);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock); #3;
         nchk++; if (fifo_out_wr_en !== 1'b0) begin nerr++; $display("FAIL bp_wr_en%0d got %b want 0", i, fifo_out_wr_en); end
         nchk++; if (fifo_out_din !== ref_px(8'h11)) begin nerr++; $display("FAIL bp_hold%0d got %h want %h", i, fifo_out_din, ref_px(8'h11)); end
      end
      nchk++; if (pop_cyc.size() !== 1) begin nerr++; $display("FAIL bp_pops got %0d want 1", pop_cyc.size()); end
      nchk++; if (wr_cyc.size() !== 0) begin nerr++; $display("FAIL bp_writes got %0d want 0", wr_cyc.size()); end
      @(negedge clock);
      fifo_out_full = 1'b0;
      repeat (6) @(negedge clock);
      #3;
      nchk++; if (wr_dat.size() !== 3) begin nerr++; $display("FAIL bp_release_count got %0d want 3", wr_dat.size()); end
      if (wr_dat.size() == 3) begin
         nchk++; if (wr_dat[0] !== ref_px(8'h11) || wr_dat[1] !== ref_px(8'h22) || wr_dat[2] !== ref_px(8'h33)) begin
            nerr++; $display("FAIL bp_order got %h %h %h want %h %h %h", wr_dat[0], wr_dat[1], wr_dat[2],
                             ref_px(8'h11), ref_px(8'h22), ref_px(8'h33));
         end
         nchk++; if (wr_cyc[1] !== wr_cyc[0] + 1 || wr_cyc[2] !== wr_cyc[0] + 2) begin
            nerr++; $display("FAIL bp_consec got %0d %0d %0d want consecutive", wr_cyc[0], wr_cyc[1], wr_cyc[2]);
         end
      end
   endtask

   task automatic test_frame();
      do_reset();
      for (int i = 1; i <= 8; i++) in_q.push_back(8'(i));
      repeat (14) @(negedge clock);
      #3;
      nchk++; if (wr_dat.size() !== 8) begin nerr++; $display("FAIL frame_wr_count got %0d want 8", wr_dat.size()); end
      nchk++; if (fd_cyc.size() !== 2) begin nerr++; $display("FAIL frame_fd_count got %0d want 2", fd_cyc.size()); end
      nchk++; if (fd_rd_viol !== 0) begin nerr++; $display("FAIL frame_eof_pop got %0d want 0", fd_rd_viol); end
      if (wr_dat.size() == 8 && fd_cyc.size() == 2) begin
         for (int i = 0; i < 8; i++) begin
            nchk++; if (wr_dat[i] !== ref_px(8'(i + 1))) begin nerr++; $display("FAIL frame_px%0d got %h want %h", i, wr_dat[i], ref_px(8'(i + 1))); end
         end
         nchk++; if (fd_cyc[0] !== wr_cyc[3] + 1) begin nerr++; $display("FAIL frame_fd0 got %0d want %0d", fd_cyc[0], wr_cyc[3] + 1); end
         nchk++; if (fd_cyc[1] !== wr_cyc[7] + 1) begin nerr++; $display("FAIL frame_fd1 got %0d want %0d", fd_cyc[1], wr_cyc[7] + 1); end
      end
      // Count must have wrapped: a third frame of exactly four pixels completes on its own.
      for (int i = 9; i <= 12; i++) in_q.push_back(8'(i));
      repeat (8) @(negedge clock);
      #3;
      nchk++; if (fd_cyc.size() !== 3 || wr_cyc.size() !== 12) begin
         nerr++; $display("FAIL frame_wrap got fd %0d wr %0d want fd 3 wr 12", fd_cyc.size(), wr_cyc.size());
      end else begin
         nchk++; if (fd_cyc[2] !== wr_cyc[11] + 1) begin nerr++; $display("FAIL frame_fd2 got %0d want %0d", fd_cyc[2], wr_cyc[11] + 1); end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      fifo_out_full = 1'b1;
      in_q.push_back(8'hA1); in_q.push_back(8'hA2); in_q.push_back(8'hA3);
      @(negedge clock); fifo_out_full = 1'b0;
      @(negedge clock);
      @(negedge clock); fifo_out_full = 1'b1;
      #3;
      nchk++; if (wr_cyc.size() !== 2) begin nerr++; $display("FAIL mid_pre_writes got %0d want 2", wr_cyc.size()); end
      nchk++; if (fifo_out_din !== ref_px(8'hA3)) begin nerr++; $display("FAIL mid_held got %h want %h", fifo_out_din, ref_px(8'hA3)); end
      @(negedge clock);
      reset = 1'b1; in_q.delete();
      repeat (2) @(negedge clock);
      reset = 1'b0; fifo_out_full = 1'b0;
      clear_logs();
      for (int i = 0; i < 4; i++) in_q.push_back(8'hB1 + 8'(i));
      repeat (8) @(negedge clock);
      #3;
      nchk++; if (wr_dat.size() !== 4) begin nerr++; $display("FAIL mid_post_count got %0d want 4", wr_dat.size()); end
      nchk++; if (fd_cyc.size() !== 1) begin nerr++; $display("FAIL mid_fd_count got %0d want 1", fd_cyc.size()); end
      if (wr_dat.size() == 4 && fd_cyc.size() == 1) begin
         for (int i = 0; i < 4; i++) begin
            nchk++; if (wr_dat[i] !== ref_px(8'hB1 + 8'(i))) begin nerr++; $display("FAIL mid_px%0d got %h want %h", i, wr_dat[i], ref_px(8'hB1 + 8'(i))); end
         end
         nchk++; if (fd_cyc[0] !== wr_cyc[3] + 1) begin nerr++; $display("FAIL mid_fd_cyc got %0d want %0d", fd_cyc[0], wr_cyc[3] + 1); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_expand_sat();
      test_backpressure();
      test_frame();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
